m68k_bus_arbiter: RTL and testbench

- Shares the 68000 bus between the Pi-driven transaction engine and an external bus master, such as Amiga DMA-capable cards, using the 68000 BR_n/BG_n/BGACK_n protocol.
- Sits beside the transaction state machine in the PI_CLK (~200 MHz) domain.
- Gates when the engine may start a cycle (S1→S2).
- Controls the tristate enables of address, data, AS/UDS/LDS/RW/FC, so those lines float while another master owns the bus.

---
 rtl/m68k_bus_arbiter_pkg.sv | 39 +++
 rtl/m68k_bus_arbiter_sync2.sv | 30 +++
 rtl/m68k_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_m68k_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the 68000 bus arbiter: FSM states, reported state codes,
// register map addresses and the REG_STATUS field position of arb_state.
package m68k_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_OWN,
    ST_PEND,
    ST_GRANT,
    ST_MASTER,
    ST_RECLAIM
  } arb_fsm_e;

  localparam logic [1:0] ARB_OWN    = 2'd0;
  localparam logic [1:0] ARB_PEND   = 2'd1;
  localparam logic [1:0] ARB_GRANT  = 2'd2;
  localparam logic [1:0] ARB_MASTER = 2'd3;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_ADDR   = 8'h08;
  localparam logic [7:0] REG_DATA   = 8'h0C;

  localparam int unsigned REG_STATUS_ARB_LSB = 8;
  localparam int unsigned REG_STATUS_ARB_MSB = 9;

  // RECLAIM is transient and reports as OWN to software.
  function automatic logic [1:0] arb_code(input arb_fsm_e s);
    logic [1:0] code;
    code = ARB_OWN;
    case (s)
      ST_PEND:   code = ARB_PEND;
      ST_GRANT:  code = ARB_GRANT;
      ST_MASTER: code = ARB_MASTER;
      default:   code = ARB_OWN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/m68k_bus_arbiter_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to 1; suits active-low
// 68000 bus strobes (BR_n, BGACK_n, IPL, RESET).
module m68k_bus_arbiter_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 BR_n/BG_n/BGACK_n arbiter between the Pi transaction engine and an external
// bus master. Optional grant timeout enabled by defining ARB_GRANT_TIMEOUT_EN.
module m68k_bus_arbiter
  import m68k_bus_arbiter_pkg::*;
#(
  parameter int unsigned GRANT_TIMEOUT = 16,
  parameter int unsigned MIN_OWN       = 2,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       PI_CLK,
  input  logic       RST_n,
  input  logic       c7m_rising,
  input  logic       c7m_falling,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  input  logic       txn_active,
  input  logic       cpu_reset,
  output logic       M68K_BG_n,
  output logic       bus_owned,
  output logic       drive_en,
  output logic [1:0] arb_state
);

  localparam logic [CNT_W-1:0] CNT_SAT =
    CNT_W'((GRANT_TIMEOUT > MIN_OWN) ? GRANT_TIMEOUT : MIN_OWN);
  localparam logic [CNT_W-1:0] MIN_OWN_C = CNT_W'(MIN_OWN);

  logic br_s, bgack_s;

  m68k_bus_arbiter_sync2 u_sync_br (
    .clk   (PI_CLK),
    .rst_n (RST_n),
    .d     (M68K_BR_n),
    .q     (br_s)
  );

  m68k_bus_arbiter_sync2 u_sync_bgack (
    .clk   (PI_CLK),
    .rst_n (RST_n),
    .d     (M68K_BGACK_n),
    .q     (bgack_s)
  );

  arb_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rise_seen_q, rise_seen_d;
  logic             bg_n_q, bg_n_d;
  logic             bus_owned_q, bus_owned_d;
  logic             drive_en_q, drive_en_d;
  logic [1:0]       arb_state_q, arb_state_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rise_seen_d = rise_seen_q;
    cnt_inc     = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);

    case (state_q)
      ST_OWN: begin
        if (c7m_falling) begin
          cnt_d = cnt_inc;
          if (!br_s && bgack_s && (cnt_q >= MIN_OWN_C) && !cpu_reset)
            state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (cpu_reset || br_s) begin
          state_d = ST_OWN;
        end else if (c7m_falling && !txn_active) begin
          state_d = ST_GRANT;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        rise_seen_d = 1'b0;
        if (cpu_reset) begin
          state_d = ST_OWN;
          cnt_d   = '0;
        end else if (c7m_falling) begin
          cnt_d = cnt_inc;
          if (!bgack_s)
            state_d = ST_MASTER;
          else if (br_s)
            state_d = ST_RECLAIM;
`ifdef ARB_GRANT_TIMEOUT_EN
          else if (cnt_inc >= CNT_W'(GRANT_TIMEOUT))
            state_d = ST_RECLAIM;
`endif
        end
      end
      ST_MASTER: begin
        rise_seen_d = 1'b0;
        if (c7m_falling && bgack_s)
          state_d = ST_RECLAIM;
      end
      ST_RECLAIM: begin
        // One full c7m cycle: a rising strobe must be seen before the falling one.
        if (c7m_falling && rise_seen_q) begin
          state_d     = ST_OWN;
          cnt_d       = '0;
          rise_seen_d = 1'b0;
        end else if (c7m_rising) begin
          rise_seen_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_OWN;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they move on the same edge.
    bg_n_d      = (state_d != ST_GRANT);
    drive_en_d  = (state_d == ST_OWN) || (state_d == ST_PEND);
    bus_owned_d = (state_d == ST_OWN);
    arb_state_d = arb_code(state_d);
  end

  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_OWN;
      cnt_q       <= '0;
      rise_seen_q <= 1'b0;
      bg_n_q      <= 1'b1;
      bus_owned_q <= 1'b1;
      drive_en_q  <= 1'b1;
      arb_state_q <= ARB_OWN;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_seen_q <= rise_seen_d;
      bg_n_q      <= bg_n_d;
      bus_owned_q <= bus_owned_d;
      drive_en_q  <= drive_en_d;
      arb_state_q <= arb_state_d;
    end
  end

  assign M68K_BG_n = bg_n_q;
  assign bus_owned = bus_owned_q;
  assign drive_en  = drive_en_q;
  assign arb_state = arb_state_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed self-checking bench for m68k_bus_arbiter; honours ARB_GRANT_TIMEOUT_EN
// so the timeout scenario matches the build under test.
module tb_m68k_bus_arbiter;

  logic       PI_CLK;
  logic       RST_n;
  logic       c7m_rising;
  logic       c7m_falling;
  logic       M68K_BR_n;
  logic       M68K_BGACK_n;
  logic       txn_active;
  logic       cpu_reset;
  logic       M68K_BG_n;
  logic       bus_owned;
  logic       drive_en;
  logic [1:0] arb_state;

  int n_cmp;
  int n_bad;

  // Observed vector: {BG_n, drive_en, bus_owned, arb_state}
  localparam logic [4:0] X_OWN     = 5'b1_1_1_00;
  localparam logic [4:0] X_PEND    = 5'b1_1_0_01;
  localparam logic [4:0] X_GRANT   = 5'b0_0_0_10;
  localparam logic [4:0] X_MASTER  = 5'b1_0_0_11;
  localparam logic [4:0] X_RECLAIM = 5'b1_0_0_00;

  m68k_bus_arbiter #(
    .GRANT_TIMEOUT (16),
    .MIN_OWN       (2),
    .CNT_W         (5)
  ) dut (
    .PI_CLK       (PI_CLK),
    .RST_n        (RST_n),
    .c7m_rising   (c7m_rising),
    .c7m_falling  (c7m_falling),
    .M68K_BR_n    (M68K_BR_n),
    .M68K_BGACK_n (M68K_BGACK_n),
    .txn_active   (txn_active),
    .cpu_reset    (cpu_reset),
    .M68K_BG_n    (M68K_BG_n),
    .bus_owned    (bus_owned),
    .drive_en     (drive_en),
    .arb_state    (arb_state)
  );

  initial begin
    PI_CLK = 1'b0;
    forever #5 PI_CLK = ~PI_CLK;
  end

  // c7m strobes: 8 PI_CLK period, rising at phase 0, falling at phase 4.
  initial begin
    int unsigned ph;
    ph          = 0;
    c7m_rising  = 1'b0;
    c7m_falling = 1'b0;
    forever begin
      @(negedge PI_CLK);
      ph          = (ph + 1) % 8;
      c7m_rising  = (ph == 0);
      c7m_falling = (ph == 4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] obs();
    return {M68K_BG_n, drive_en, bus_owned, arb_state};
  endfunction

  // Advance to just after the PI_CLK edge that sampled a c7m_falling strobe.
  task automatic fall();
    do @(posedge PI_CLK); while (!c7m_falling);
    #1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0; M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1;
    txn_active = 1'b0; cpu_reset = 1'b0;
    #23;
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", obs(), X_OWN);
    end
    #4 RST_n = 1'b1;
  endtask

  task automatic test_idle_grant();
    repeat (3) fall();
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL idle_own: got %b want %b", obs(), X_OWN);
    end
    M68K_BR_n = 1'b0;
    fall();
    n_cmp++;
    if (obs() !== X_PEND) begin
      n_bad++; $display("FAIL idle_pend: got %b want %b", obs(), X_PEND);
    end
    fall();
    n_cmp++;
    if (obs() !== X_GRANT) begin
      n_bad++; $display("FAIL idle_grant: got %b want %b", obs(), X_GRANT);
    end
    M68K_BGACK_n = 1'b0; M68K_BR_n = 1'b1;
    fall();
    n_cmp++;
    if (obs() !== X_MASTER) begin
      n_bad++; $display("FAIL idle_master: got %b want %b", obs(), X_MASTER);
    end
  endtask

  task automatic test_release();
    M68K_BGACK_n = 1'b1;
    fall();
    n_cmp++;
    if (obs() !== X_RECLAIM) begin
      n_bad++; $display("FAIL release_reclaim: got %b want %b", obs(), X_RECLAIM);
    end
    fall();
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL release_own: got %b want %b", obs(), X_OWN);
    end
    // Counter restarts at 0: two falling edges must pass before a grant.
    M68K_BR_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fall();
      n_cmp++;
      if (obs() !== X_OWN) begin
        n_bad++; $display("FAIL min_own_hold%0d: got %b want %b", i, obs(), X_OWN);
      end
    end
    fall();
    n_cmp++;
    if (obs() !== X_PEND) begin
      n_bad++; $display("FAIL min_own_pend: got %b want %b", obs(), X_PEND);
    end
    M68K_BR_n = 1'b1;
    fall();
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL pend_withdraw: got %b want %b", obs(), X_OWN);
    end
  endtask

  task automatic test_mid_cycle();
    txn_active = 1'b1; M68K_BR_n = 1'b0;
    fall();
    n_cmp++;
    if (obs() !== X_PEND) begin
      n_bad++; $display("FAIL mid_pend: got %b want %b", obs(), X_PEND);
    end
    for (int i = 0; i < 4; i++) begin
      fall();
      n_cmp++;
      if (obs() !== X_PEND) begin
        n_bad++; $display("FAIL mid_hold%0d: got %b want %b", i, obs(), X_PEND);
      end
    end
    txn_active = 1'b0;
    fall();
    n_cmp++;
    if (obs() !== X_GRANT) begin
      n_bad++; $display("FAIL mid_grant: got %b want %b", obs(), X_GRANT);
    end
  endtask

  task automatic test_withdrawn();
    M68K_BR_n = 1'b1;
    fall();
    n_cmp++;
    if (obs() !== X_RECLAIM) begin
      n_bad++; $display("FAIL withdraw_reclaim: got %b want %b", obs(), X_RECLAIM);
    end
    fall();
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL withdraw_own: got %b want %b", obs(), X_OWN);
    end
  endtask

  task automatic test_timeout();
    M68K_BR_n = 1'b0;
    repeat (3) fall();
    n_cmp++;
    if (obs() !== X_PEND) begin
      n_bad++; $display("FAIL to_pend: got %b want %b", obs(), X_PEND);
    end
    fall();
    n_cmp++;
    if (obs() !== X_GRANT) begin
      n_bad++; $display("FAIL to_grant: got %b want %b", obs(), X_GRANT);
    end
`ifdef ARB_GRANT_TIMEOUT_EN
    repeat (15) fall();
    n_cmp++;
    if (obs() !== X_GRANT) begin
      n_bad++; $display("FAIL to_before: got %b want %b", obs(), X_GRANT);
    end
    fall();
    n_cmp++;
    if (obs() !== X_RECLAIM) begin
      n_bad++; $display("FAIL to_expire: got %b want %b", obs(), X_RECLAIM);
    end
    M68K_BR_n = 1'b1;
    fall();
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL to_own: got %b want %b", obs(), X_OWN);
    end
`else
    repeat (100) fall();
    n_cmp++;
    if (obs() !== X_GRANT) begin
      n_bad++; $display("FAIL to_hold100: got %b want %b", obs(), X_GRANT);
    end
    cpu_reset = 1'b1;
    @(posedge PI_CLK); #1;
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL grant_cpu_reset: got %b want %b", obs(), X_OWN);
    end
    cpu_reset = 1'b0; M68K_BR_n = 1'b1;
`endif
  endtask

  task automatic test_cpu_reset();
    repeat (3) fall();
    M68K_BR_n = 1'b0;
    fall();
    n_cmp++;
    if (obs() !== X_PEND) begin
      n_bad++; $display("FAIL cr_pend: got %b want %b", obs(), X_PEND);
    end
    cpu_reset = 1'b1;
    @(posedge PI_CLK); #1;
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL cr_pend_to_own: got %b want %b", obs(), X_OWN);
    end
    repeat (2) fall();
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL cr_block: got %b want %b", obs(), X_OWN);
    end
    cpu_reset = 1'b0; M68K_BR_n = 1'b1;
    fall();
  endtask

  task automatic test_master_reset();
    M68K_BR_n = 1'b0;
    repeat (2) fall();
    n_cmp++;
    if (obs() !== X_GRANT) begin
      n_bad++; $display("FAIL mr_grant: got %b want %b", obs(), X_GRANT);
    end
    M68K_BGACK_n = 1'b0;
    fall();
    cpu_reset = 1'b1;
    fall();
    n_cmp++;
    if (obs() !== X_MASTER) begin
      n_bad++; $display("FAIL mr_cpu_reset_ignored: got %b want %b", obs(), X_MASTER);
    end
    cpu_reset = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== X_OWN) begin
      n_bad++; $display("FAIL mr_async_reset: got %b want %b", obs(), X_OWN);
    end
    M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1;
    #13 RST_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_idle_grant();
    test_release();
    test_mid_cycle();
    test_withdrawn();
    test_timeout();
    test_cpu_reset();
    test_master_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
